// File: rtl/ibex_pmp_check_arbiter.sv
// ibex_pmp_check_arbiter
//
// Time-shares one PMP access-checking channel among NumReq requesters
// (for example a debug port, a DMA engine and a trace unit). A round-robin
// arbiter picks one valid requester in IDLE. Its request is registered and
// driven onto the PMP channel for a full CHECK cycle. The fault result is
// then held in RESP until the owner accepts it. A PMP configuration write
// during CHECK or RESP forces a fresh check, so a stale result never leaves
// the block.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i/ready_o  per-requester request handshake (ready is one-hot or 0)
//   req_addr_i           34-bit physical address per requester
//   req_type_i           pmp_req_e encoding: EXEC=2'b00, WRITE=2'b01, READ=2'b10
//   req_priv_i           priv_lvl_e encoding: U=2'b00, S=2'b01, M=2'b11
//   rsp_valid_o/err_o    per-requester response; only the owner bit is ever set
//   rsp_ready_i          per-requester response accept (non-owner bits ignored)
//   pmp_req_*_o          registered request driven to the PMP checker channel
//   pmp_req_err_i        combinational fault result from the PMP checker
//   cfg_change_i         any pmpcfg/pmpaddr/mseccfg CSR write this cycle
//   busy_o               arbiter is not idle
module ibex_pmp_check_arbiter #(
  parameter int unsigned NumReq = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0][33:0]  req_addr_i,
  input  logic [NumReq-1:0][1:0]   req_type_i,
  input  logic [NumReq-1:0][1:0]   req_priv_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [NumReq-1:0]        rsp_err_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic [33:0]              pmp_req_addr_o,
  output logic [1:0]               pmp_req_type_o,
  output logic [1:0]               pmp_priv_mode_o,
  input  logic                     pmp_req_err_i,
  input  logic                     cfg_change_i,
  output logic                     busy_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] PMP_ACC_EXEC = 2'b00;
  localparam logic [1:0] PRIV_LVL_M   = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]      state;
  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] owner_p1;
  logic [33:0]     addr_p1;
  logic [1:0]      type_p1;
  logic [1:0]      priv_p1;
  logic            err_p2;

  logic            gnt_found;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] cand;
  logic [PtrW-1:0] ptr_next;

  // Round-robin scan: ptr, ptr+1, ... modulo NumReq; first valid wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (32'(ptr) + i >= NumReq) begin
        cand = PtrW'(32'(ptr) + i - NumReq);
      end else begin
        cand = PtrW'(32'(ptr) + i);
      end
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign ptr_next = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

  // Ready is forced low during reset even though the state is not yet IDLE-reset.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && (state == IDLE) && gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_err_o   = '0;
    if (rst_ni && (state == RESP)) begin
      rsp_valid_o[owner_p1] = 1'b1;
      rsp_err_o[owner_p1]   = err_p2;
    end
  end

  assign busy_o          = rst_ni && (state != IDLE);
  assign pmp_req_addr_o  = addr_p1;
  assign pmp_req_type_o  = type_p1;
  assign pmp_priv_mode_o = priv_p1;

  // Stage p1: grant registers the request; stage p2: check result captured.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ptr      <= '0;
      owner_p1 <= '0;
      addr_p1  <= '0;
      type_p1  <= PMP_ACC_EXEC;
      priv_p1  <= PRIV_LVL_M;
      err_p2   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            owner_p1 <= gnt_idx;
            addr_p1  <= req_addr_i[gnt_idx];
            type_p1  <= req_type_i[gnt_idx];
            priv_p1  <= req_priv_i[gnt_idx];
            ptr      <= ptr_next;
            state    <= CHECK;
          end
        end
        CHECK: begin
          // A config write this cycle makes the checker output stale: retry.
          if (!cfg_change_i) begin
            err_p2 <= pmp_req_err_i;
            state  <= RESP;
          end
        end
        RESP: begin
          // Handshake takes precedence over a concurrent config write.
          if (rsp_ready_i[owner_p1]) begin
            state <= IDLE;
          end else if (cfg_change_i) begin
            state <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_pmp_check_arbiter.sv
// Directed bench for ibex_pmp_check_arbiter with a response scoreboard.
module tb_ibex_pmp_check_arbiter;

  localparam int N = 3;

  localparam logic [1:0] ACC_EXEC  = 2'b00;
  localparam logic [1:0] ACC_WRITE = 2'b01;
  localparam logic [1:0] ACC_READ  = 2'b10;
  localparam logic [1:0] PRIV_U    = 2'b00;
  localparam logic [1:0] PRIV_S    = 2'b01;
  localparam logic [1:0] PRIV_M    = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][33:0]  req_addr;
  logic [N-1:0][1:0]   req_type;
  logic [N-1:0][1:0]   req_priv;
  logic [N-1:0]        rsp_valid;
  logic [N-1:0]        rsp_err;
  logic [N-1:0]        rsp_ready;
  logic [33:0]         pmp_addr;
  logic [1:0]          pmp_type;
  logic [1:0]          pmp_priv;
  logic                pmp_err;
  logic                cfg_change;
  logic                busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] owner;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ibex_pmp_check_arbiter #(.NumReq(N)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_type_i      (req_type),
    .req_priv_i      (req_priv),
    .rsp_valid_o     (rsp_valid),
    .rsp_err_o       (rsp_err),
    .rsp_ready_i     (rsp_ready),
    .pmp_req_addr_o  (pmp_addr),
    .pmp_req_type_o  (pmp_type),
    .pmp_priv_mode_o (pmp_priv),
    .pmp_req_err_i   (pmp_err),
    .cfg_change_i    (cfg_change),
    .busy_o          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] o, input logic b);
    exp_t e;
    e.owner = o;
    e.err   = b;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t         e;
    logic [N-1:0] ev;
    logic [N-1:0] ee;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e  = sb.pop_front();
    ev = '0;
    ee = '0;
    ev[e.owner] = 1'b1;
    ee[e.owner] = e.err;
    check({tag, "_vld"}, 64'(rsp_valid), 64'(ev));
    check({tag, "_err"}, 64'(rsp_err), 64'(ee));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish by 100000ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]   g;
    logic [N-1:0] ex;

    rst_n      = 1'b0;
    req_valid  = '1;
    req_addr   = '0;
    req_type   = '0;
    req_priv   = '0;
    rsp_ready  = '0;
    pmp_err    = 1'b0;
    cfg_change = 1'b0;

    // Reset values
    tick();
    smp();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pmp_addr", 64'(pmp_addr), 64'd0);
    check("rst_pmp_type", 64'(pmp_type), 64'(ACC_EXEC));
    check("rst_pmp_priv", 64'(pmp_priv), 64'(PRIV_M));
    tick();

    // Round-robin with all requesters valid: 0,1,2,0,1 spaced 3 cycles apart
    rst_n       = 1'b1;
    req_valid   = 3'b111;
    rsp_ready   = 3'b111;
    req_addr[0] = 34'h1_0000_0000;
    req_addr[1] = 34'h1_0000_0100;
    req_addr[2] = 34'h1_0000_0200;
    req_type[0] = ACC_READ;
    req_type[1] = ACC_WRITE;
    req_type[2] = ACC_EXEC;
    req_priv[0] = PRIV_U;
    req_priv[1] = PRIV_S;
    req_priv[2] = PRIV_M;
    for (int k = 0; k < 5; k++) begin
      g  = 2'(k % 3);
      ex = '0;
      ex[g] = 1'b1;
      smp();
      check("rr_grant", 64'(req_ready), 64'(ex));
      push(g, 1'(k % 2));
      tick();
      pmp_err = (k % 2) == 1;
      smp();
      check("rr_addr", 64'(pmp_addr), 64'(req_addr[g]));
      check("rr_type", 64'(pmp_type), 64'(req_type[g]));
      check("rr_priv", 64'(pmp_priv), 64'(req_priv[g]));
      check("rr_ready_in_check", 64'(req_ready), 64'd0);
      tick();
      smp();
      pop_check("rr_rsp");
      check("rr_ready_in_resp", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;

    // Single request: requester 1 READ 0x0_8000_0000 priv U, fault forced
    req_valid   = 3'b010;
    req_addr[1] = 34'h0_8000_0000;
    req_type[1] = ACC_READ;
    req_priv[1] = PRIV_U;
    pmp_err     = 1'b1;
    rsp_ready   = 3'b010;
    smp();
    check("single_grant", 64'(req_ready), 64'b010);
    check("single_busy_c0", 64'(busy), 64'd0);
    push(2'd1, 1'b1);
    tick();
    req_valid = '0;
    smp();
    check("single_addr", 64'(pmp_addr), 64'h0_8000_0000);
    check("single_type", 64'(pmp_type), 64'(ACC_READ));
    check("single_priv", 64'(pmp_priv), 64'(PRIV_U));
    check("single_busy_c1", 64'(busy), 64'd1);
    check("single_no_rsp_c1", 64'(rsp_valid), 64'd0);
    tick();
    smp();
    pop_check("single_rsp");
    tick();
    smp();
    check("single_busy_c3", 64'(busy), 64'd0);
    check("single_rsp_gone", 64'(rsp_valid), 64'd0);
    tick();

    // Backpressure: owner 0 withholds ready 5 cycles; requester 2 waits
    req_valid   = 3'b001;
    req_addr[0] = 34'h2_0000_0040;
    req_type[0] = ACC_WRITE;
    req_priv[0] = PRIV_S;
    rsp_ready   = '0;
    smp();
    check("bp_grant", 64'(req_ready), 64'b001);
    push(2'd0, 1'b1);
    tick();
    req_valid = 3'b100;
    pmp_err   = 1'b1;
    smp();
    check("bp_ready_in_check", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 3'b100;
    for (int h = 0; h < 5; h++) begin
      smp();
      check("bp_hold_vld", 64'(rsp_valid), 64'b001);
      check("bp_hold_err", 64'(rsp_err), 64'b001);
      check("bp_hold_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 3'b001;
    smp();
    pop_check("bp_rsp");
    check("bp_ready_at_hs", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = '0;
    pmp_err   = 1'b0;
    smp();
    check("bp_next_grant", 64'(req_ready), 64'b100);
    push(2'd2, 1'b0);
    tick();
    req_valid = '0;
    smp();
    check("bp_next_addr", 64'(pmp_addr), 64'h1_0000_0200);
    tick();
    rsp_ready = 3'b100;
    smp();
    pop_check("bp_next_rsp");
    tick();
    rsp_ready = '0;

    // Config change in CHECK and in RESP; fault 1 before the write, 0 after
    req_valid   = 3'b001;
    req_addr[0] = 34'h3_FFFF_FFFC;
    req_type[0] = ACC_EXEC;
    req_priv[0] = PRIV_M;
    pmp_err     = 1'b1;
    smp();
    check("cfg_grant", 64'(req_ready), 64'b001);
    push(2'd0, 1'b0);
    tick();
    req_valid  = '0;
    cfg_change = 1'b1;
    smp();
    check("cfg_c1_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    cfg_change = 1'b0;
    pmp_err    = 1'b0;
    smp();
    check("cfg_c2_recheck", 64'(rsp_valid), 64'd0);
    check("cfg_c2_busy", 64'(busy), 64'd1);
    tick();
    cfg_change = 1'b1;
    smp();
    check("cfg_c3_vld", 64'(rsp_valid), 64'b001);
    check("cfg_c3_err", 64'(rsp_err), 64'd0);
    tick();
    cfg_change = 1'b0;
    smp();
    check("cfg_c4_dropped", 64'(rsp_valid), 64'd0);
    check("cfg_c4_busy", 64'(busy), 64'd1);
    tick();
    rsp_ready = 3'b001;
    smp();
    pop_check("cfg_c5_rsp");
    tick();
    rsp_ready = '0;

    // Simultaneous handshake and config change in RESP
    req_valid = 3'b010;
    pmp_err   = 1'b1;
    smp();
    check("sim_grant", 64'(req_ready), 64'b010);
    push(2'd1, 1'b1);
    tick();
    req_valid = '0;
    smp();
    check("sim_busy", 64'(busy), 64'd1);
    tick();
    cfg_change = 1'b1;
    rsp_ready  = 3'b010;
    smp();
    pop_check("sim_rsp");
    tick();
    cfg_change = 1'b0;
    rsp_ready  = '0;
    smp();
    check("sim_idle_busy", 64'(busy), 64'd0);
    check("sim_idle_rsp", 64'(rsp_valid), 64'd0);
    tick();

    // Reset in RESP aborts the request; pointer restarts at 0
    req_valid   = 3'b001;
    req_addr[0] = 34'h0_1234_5678;
    pmp_err     = 1'b0;
    smp();
    check("rstmid_grant", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    tick();
    smp();
    check("rstmid_pre_vld", 64'(rsp_valid), 64'b001);
    rst_n     = 1'b0;
    req_valid = 3'b011;
    #1;
    check("rstmid_forced_vld", 64'(rsp_valid), 64'd0);
    check("rstmid_forced_ready", 64'(req_ready), 64'd0);
    check("rstmid_forced_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    smp();
    check("rstmid_pmp_addr", 64'(pmp_addr), 64'd0);
    check("rstmid_pmp_type", 64'(pmp_type), 64'(ACC_EXEC));
    check("rstmid_pmp_priv", 64'(pmp_priv), 64'(PRIV_M));
    check("rstmid_rsp", 64'(rsp_valid), 64'd0);
    check("rstmid_grant_low", 64'(req_ready), 64'b001);
    push(2'd0, 1'b1);
    tick();
    req_valid = '0;
    pmp_err   = 1'b1;
    tick();
    rsp_ready = 3'b001;
    smp();
    pop_check("rstmid_rsp_after");
    tick();
    rsp_ready = '0;
    smp();
    check("end_idle", 64'(busy), 64'd0);
    check("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
